// File: rtl/rvga_lsu.sv
// rvga_lsu: single-outstanding load/store unit for the rvga core.
// Takes one memory op from execute, issues one word-aligned memory request,
// waits for load data with a bounded timeout, and returns a one-cycle
// writeback response. Misaligned or illegal ops answer with an error
// and never reach memory. Every output is a flop or a decode of the
// state register, so req_* never reaches mem_* or resp_* in one cycle.
module rvga_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_v_i,
  output logic        req_ready_o,
  input  logic        req_is_st_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        mem_v_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        resp_v_o,
  output logic        resp_we_o,
  output logic [4:0]  resp_rd_o,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  // Last WAIT cycle index; the op times out at the end of this cycle
  // unless read data arrives in it.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

  // Encodings accepted for loads (lb, lh, lw, lbu, lhu) and stores (sb, sh, sw).
  function automatic logic op_legal(input logic is_st, input logic [2:0] funct3);
    logic ok;
    if (is_st) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: ok = 1'b1;
        default:                ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        default:                                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Natural alignment by access size (funct3[1:0]: 00 byte, 01 half, 10 word).
  function automatic logic op_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      2'b00:   ok = 1'b1;
      2'b01:   ok = (addr_lo[0] == 1'b0);
      2'b10:   ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Replicate store data across all lanes so the mask alone picks the bytes.
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      2'b10:   d = wdata;
      default: d = 32'd0;
    endcase
    return d;
  endfunction

  // Byte-enable mask for a store of the given size at the given lane.
  function automatic logic [3:0] store_wmask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << addr_lo;
      2'b01:   m = 4'b0011 << addr_lo;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0]  funct3,
                                               input logic [1:0]  addr_lo,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] d;
    case (addr_lo)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      2'b11:   b = rdata[31:24];
      default: b = 8'd0;
    endcase
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      3'b000:  d = {{24{b[7]}}, b};
      3'b100:  d = {24'd0, b};
      3'b001:  d = {{16{h[15]}}, h};
      3'b101:  d = {16'd0, h};
      3'b010:  d = rdata;
      default: d = 32'd0;
    endcase
    return d;
  endfunction

  logic [1:0]  state_r;
  logic [1:0]  state_s;
  logic [7:0]  count_r;
  logic        is_st_r;
  logic [2:0]  funct3_r;
  logic [1:0]  addr_lo_r;
  logic [4:0]  rd_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic [3:0]  mem_wmask_r;
  logic        resp_we_r;
  logic [4:0]  resp_rd_r;
  logic [31:0] resp_data_r;
  logic        resp_err_r;
  logic        accept_s;
  logic        req_ok_s;
  logic        timeout_s;
  logic [31:0] load_data_s;

  // Next-state selection plus the request-acceptance and timeout decodes.
  always_comb begin
    accept_s    = req_v_i && (state_r == IDLE);
    req_ok_s    = op_legal(req_is_st_i, req_funct3_i) &&
                  op_aligned(req_funct3_i[1:0], req_addr_i[1:0]);
    timeout_s   = (count_r == TIMEOUT_LAST);
    load_data_s = load_extract(funct3_r, addr_lo_r, mem_rdata_i);
    state_s     = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = req_ok_s ? REQ : RESP;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (mem_ready_i) begin
          state_s = is_st_r ? RESP : WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid_i || timeout_s) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, captured request, memory-channel and response registers.
  // Response fields default to zero each cycle, so they are non-zero only
  // during the single RESP cycle that follows the edge that sets them.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      count_r     <= 8'd0;
      is_st_r     <= 1'b0;
      funct3_r    <= 3'd0;
      addr_lo_r   <= 2'd0;
      rd_r        <= 5'd0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      mem_wmask_r <= 4'd0;
      resp_we_r   <= 1'b0;
      resp_rd_r   <= 5'd0;
      resp_data_r <= 32'd0;
      resp_err_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      resp_we_r   <= 1'b0;
      resp_rd_r   <= 5'd0;
      resp_data_r <= 32'd0;
      resp_err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            is_st_r   <= req_is_st_i;
            funct3_r  <= req_funct3_i;
            addr_lo_r <= req_addr_i[1:0];
            rd_r      <= req_rd_i;
            count_r   <= 8'd0;
            if (req_ok_s) begin
              mem_we_r    <= req_is_st_i;
              mem_addr_r  <= {req_addr_i[31:2], 2'b00};
              mem_wdata_r <= req_is_st_i ? store_wdata(req_funct3_i[1:0], req_wdata_i) : 32'd0;
              mem_wmask_r <= req_is_st_i ? store_wmask(req_funct3_i[1:0], req_addr_i[1:0]) : 4'd0;
            end else begin
              resp_err_r <= 1'b1;
              resp_rd_r  <= req_rd_i;
            end
          end
        end
        REQ: begin
          // Read data seen here belongs to no accepted request and is dropped.
          if (mem_ready_i) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            mem_wmask_r <= 4'd0;
            count_r     <= 8'd0;
            resp_rd_r   <= rd_r;
          end
        end
        WAIT: begin
          // Data arriving on the timeout cycle still completes normally.
          if (mem_rvalid_i) begin
            resp_we_r   <= (rd_r != 5'd0);
            resp_rd_r   <= rd_r;
            resp_data_r <= load_data_s;
          end else if (timeout_s) begin
            resp_err_r <= 1'b1;
            resp_rd_r  <= rd_r;
          end else begin
            count_r <= count_r + 8'd1;
          end
        end
        RESP: begin
          count_r <= 8'd0;
        end
        default: begin
          count_r <= 8'd0;
        end
      endcase
    end
  end

  assign req_ready_o = (state_r == IDLE);
  assign mem_v_o     = (state_r == REQ);
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign mem_wmask_o = mem_wmask_r;
  assign resp_v_o    = (state_r == RESP);
  assign resp_we_o   = resp_we_r;
  assign resp_rd_o   = resp_rd_r;
  assign resp_data_o = resp_data_r;
  assign resp_err_o  = resp_err_r;

endmodule
